// File: rtl/cfm_pkg.sv
// Shared constants, shift helper and stage-3 payload type for complex_fix_mul_pipe.
package cfm_pkg;

    localparam int REAL = 0;
    localparam int IMAG = 1;

    // The payload struct is sized for the widest supported configuration.
    localparam int OUT_MAX = 64;
    localparam int TAG_MAX = 32;

    function automatic int calc_sh(input int in_frac, input int out_frac);
        return 2 * in_frac - out_frac;
    endfunction

    typedef struct packed {
        logic signed [OUT_MAX-1:0] re;
        logic signed [OUT_MAX-1:0] im;
        logic [TAG_MAX-1:0]        tag;
        logic                      sat;
    } s3_payload_t;

endpackage

// File: rtl/complex_fix_mul_pipe_if.sv
// Operand/result handshake bundle for complex_fix_mul_pipe; master drives operands, slave is the multiplier.
interface complex_fix_mul_pipe_if #(
    parameter int IN_BITS  = 18,
    parameter int OUT_BITS = 20,
    parameter int TAG_BITS = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_BITS-1:0]  in_x_re;
    logic signed [IN_BITS-1:0]  in_x_im;
    logic signed [IN_BITS-1:0]  in_y_re;
    logic signed [IN_BITS-1:0]  in_y_im;
    logic                       in_conj;
    logic [TAG_BITS-1:0]        in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [OUT_BITS-1:0] out_re;
    logic signed [OUT_BITS-1:0] out_im;
    logic [TAG_BITS-1:0]        out_tag;
    logic                       out_sat;
    logic                       busy;

    modport master (
        output in_valid, in_x_re, in_x_im, in_y_re, in_y_im, in_conj, in_tag, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_tag, out_sat, busy
    );

    modport slave (
        input  in_valid, in_x_re, in_x_im, in_y_re, in_y_im, in_conj, in_tag, out_ready,
        output in_ready, out_valid, out_re, out_im, out_tag, out_sat, busy
    );
endinterface

// File: rtl/cfm_round_sat.sv
// Combinational scale-down (round-half-up when CMPLX_MUL_ROUND_EN is defined, else truncate) and saturate.
module cfm_round_sat #(
    parameter int IN_W     = 38,
    parameter int OUT_BITS = 20,
    parameter int SH       = 16
) (
    input  logic signed [IN_W-1:0]     in_i,
    output logic signed [OUT_BITS-1:0] out_o,
    output logic                       sat_o
);
    // One guard bit so the rounding add can never overflow.
    localparam int W = IN_W + 1;
    localparam logic signed [W-1:0] MAXV = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = ~MAXV;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shf;

    assign ext = {in_i[IN_W-1], in_i};

`ifdef CMPLX_MUL_ROUND_EN
    if (SH > 0) begin : g_rnd
        localparam logic signed [W-1:0] HALF = W'(1) << (SH - 1);
        assign rnd = ext + HALF;
    end else begin : g_nornd
        assign rnd = ext;
    end
`else
    assign rnd = ext;
`endif

    assign shf = rnd >>> SH;

    always_comb begin
        out_o = shf[OUT_BITS-1:0];
        sat_o = 1'b0;
        if (shf > MAXV) begin
            out_o = MAXV[OUT_BITS-1:0];
            sat_o = 1'b1;
        end else if (shf < MINV) begin
            out_o = MINV[OUT_BITS-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/complex_fix_mul_pipe.sv
// Three-stage complex fixed-point multiplier x*y or x*conj(y) with stall-all back-pressure.
// Optional build macro: CMPLX_MUL_ROUND_EN (round-half-up instead of truncation).
module complex_fix_mul_pipe
    import cfm_pkg::*;
#(
    parameter int IN_BITS  = 18,
    parameter int IN_FRAC  = 16,
    parameter int OUT_BITS = 20,
    parameter int OUT_FRAC = 16,
    parameter int TAG_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    complex_fix_mul_pipe_if.slave  bus
);
    localparam int SH = calc_sh(IN_FRAC, OUT_FRAC);
    localparam int PW = 2 * IN_BITS + 1;
    localparam int SW = 2 * IN_BITS + 2;

    if (OUT_FRAC < 0 || OUT_FRAC > 2 * IN_FRAC) begin : g_bad_frac
        $error("complex_fix_mul_pipe: OUT_FRAC must lie in 0..2*IN_FRAC");
    end
    if (OUT_BITS > OUT_MAX || TAG_BITS > TAG_MAX || OUT_BITS > SW) begin : g_bad_width
        $error("complex_fix_mul_pipe: OUT_BITS/TAG_BITS exceed supported range");
    end

    logic advance;
    logic vld_p1_q, vld_p2_q, vld_p3_q;

    assign advance      = !vld_p3_q || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage 1: operands, with the conjugate folded into a widened d'
    logic signed [IN_BITS-1:0] a_p1_q, b_p1_q, c_p1_q;
    logic signed [IN_BITS:0]   d_ext, d_p1_d, d_p1_q;
    logic [TAG_BITS-1:0]       tag_p1_q;

    assign d_ext  = {bus.in_y_im[IN_BITS-1], bus.in_y_im};
    assign d_p1_d = bus.in_conj ? -d_ext : d_ext;

    always_ff @(posedge clk) begin
        if (advance) begin
            a_p1_q   <= bus.in_x_re;
            b_p1_q   <= bus.in_x_im;
            c_p1_q   <= bus.in_y_re;
            d_p1_q   <= d_p1_d;
            tag_p1_q <= bus.in_tag;
        end
    end

    // Stage 2: full-precision partial products
    logic signed [PW-1:0] ac_p2_q, bd_p2_q, bc_p2_q, ad_p2_q;
    logic signed [PW-1:0] ac_p2_d, bd_p2_d, bc_p2_d, ad_p2_d;
    logic [TAG_BITS-1:0]  tag_p2_q;

    assign ac_p2_d = PW'(a_p1_q) * PW'(c_p1_q);
    assign bd_p2_d = PW'(b_p1_q) * PW'(d_p1_q);
    assign bc_p2_d = PW'(b_p1_q) * PW'(c_p1_q);
    assign ad_p2_d = PW'(a_p1_q) * PW'(d_p1_q);

    always_ff @(posedge clk) begin
        if (advance) begin
            ac_p2_q  <= ac_p2_d;
            bd_p2_q  <= bd_p2_d;
            bc_p2_q  <= bc_p2_d;
            ad_p2_q  <= ad_p2_d;
            tag_p2_q <= tag_p1_q;
        end
    end

    // Stage 3: combine, scale, saturate
    logic signed [SW-1:0]       sum_p2 [2];
    logic signed [OUT_BITS-1:0] res_p2 [2];
    logic                       clip_p2 [2];
    s3_payload_t                p3_d, p3_q;

    assign sum_p2[REAL] = SW'(ac_p2_q) - SW'(bd_p2_q);
    assign sum_p2[IMAG] = SW'(bc_p2_q) + SW'(ad_p2_q);

    cfm_round_sat #(.IN_W(SW), .OUT_BITS(OUT_BITS), .SH(SH)) u_rs_re (
        .in_i  (sum_p2[REAL]),
        .out_o (res_p2[REAL]),
        .sat_o (clip_p2[REAL])
    );

    cfm_round_sat #(.IN_W(SW), .OUT_BITS(OUT_BITS), .SH(SH)) u_rs_im (
        .in_i  (sum_p2[IMAG]),
        .out_o (res_p2[IMAG]),
        .sat_o (clip_p2[IMAG])
    );

    always_comb begin
        p3_d     = '0;
        p3_d.re  = OUT_MAX'(res_p2[REAL]);
        p3_d.im  = OUT_MAX'(res_p2[IMAG]);
        p3_d.tag = TAG_MAX'(tag_p2_q);
        p3_d.sat = clip_p2[REAL] || clip_p2[IMAG];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            p3_q     <= '0;
        end else if (advance) begin
            vld_p1_q <= bus.in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
            p3_q     <= p3_d;
        end
    end

    assign bus.out_valid = vld_p3_q;
    assign bus.out_re    = p3_q.re[OUT_BITS-1:0];
    assign bus.out_im    = p3_q.im[OUT_BITS-1:0];
    assign bus.out_tag   = p3_q.tag[TAG_BITS-1:0];
    assign bus.out_sat   = p3_q.sat;
    assign bus.busy      = vld_p1_q || vld_p2_q || vld_p3_q;
endmodule

// File: tb/tb_complex_fix_mul_pipe.sv
// Directed bench for complex_fix_mul_pipe at default parameters (Q2.16 in, Q4.16 out).
module tb_complex_fix_mul_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic bp_done = 1'b0;

    always #5 clk = ~clk;

    complex_fix_mul_pipe_if #(.IN_BITS(18), .OUT_BITS(20), .TAG_BITS(4)) bus ();

    complex_fix_mul_pipe #(
        .IN_BITS(18), .IN_FRAC(16), .OUT_BITS(20), .OUT_FRAC(16), .TAG_BITS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_beat(input string tg,
                            input logic [17:0] xr, input logic [17:0] xi,
                            input logic [17:0] yr, input logic [17:0] yi,
                            input logic cj, input logic [3:0] tag,
                            input logic [19:0] er, input logic [19:0] ei, input logic es);
        int k;
        @(negedge clk);
        bus.in_x_re  = xr;
        bus.in_x_im  = xi;
        bus.in_y_re  = yr;
        bus.in_y_im  = yi;
        bus.in_conj  = cj;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 10);
        chk({tg, "_lat"}, k, 3);
        chk({tg, "_re"},  $unsigned(bus.out_re), er);
        chk({tg, "_im"},  $unsigned(bus.out_im), ei);
        chk({tg, "_sat"}, bus.out_sat, es);
        chk({tg, "_tag"}, bus.out_tag, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x_re   = '0;
        bus.in_x_im   = '0;
        bus.in_y_re   = '0;
        bus.in_y_im   = '0;
        bus.in_conj   = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_busy",      bus.busy, 1'b0);
        chk("rst_out_re",    $unsigned(bus.out_re), 20'h0);
        chk("rst_out_tag",   bus.out_tag, 4'h0);
        chk("rst_out_sat",   bus.out_sat, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);

        // (1+0.5i)(0.5+1i) = 0 + 1.25i ; conj: 1.0 - 0.75i
        run_beat("basic", 18'h10000, 18'h08000, 18'h08000, 18'h10000, 1'b0, 4'h3,
                 20'h00000, 20'h14000, 1'b0);
        run_beat("conj",  18'h10000, 18'h08000, 18'h08000, 18'h10000, 1'b1, 4'h5,
                 20'h10000, 20'hF4000, 1'b0);
`ifdef CMPLX_MUL_ROUND_EN
        run_beat("rnd_pos", 18'h00001, 18'h0, 18'h08000, 18'h0, 1'b0, 4'h1, 20'h00001, 20'h0, 1'b0);
        run_beat("rnd_neg", 18'h3FFFF, 18'h0, 18'h08000, 18'h0, 1'b0, 4'h2, 20'h00000, 20'h0, 1'b0);
`else
        run_beat("rnd_pos", 18'h00001, 18'h0, 18'h08000, 18'h0, 1'b0, 4'h1, 20'h00000, 20'h0, 1'b0);
        run_beat("rnd_neg", 18'h3FFFF, 18'h0, 18'h08000, 18'h0, 1'b0, 4'h2, 20'hFFFFF, 20'h0, 1'b0);
`endif
        // conj of d=-2.0 must become +2.0: re = 4 + 4 = 8 -> clip
        run_beat("sat_re",  18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b1, 4'h6,
                 20'h7FFFF, 20'h00000, 1'b1);
        run_beat("sat_im",  18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b0, 4'h7,
                 20'h00000, 20'h7FFFF, 1'b1);
        // re = 8 - 2^-15 just fits, im = 2^-15
        run_beat("near_max", 18'h20000, 18'h20000, 18'h20000, 18'h1FFFF, 1'b0, 4'h8,
                 20'h7FFFE, 20'h00002, 1'b0);

        // Back-pressure stream: 8 beats, out_ready pattern 1,0,0,1
        fork
            begin : drv
                for (int k = 0; k < 8; k++) begin
                    int  tries;
                    logic acc;
                    bus.in_x_re  = 18'(k << 12);
                    bus.in_x_im  = '0;
                    bus.in_y_re  = 18'h10000;
                    bus.in_y_im  = '0;
                    bus.in_conj  = 1'b0;
                    bus.in_tag   = 4'(k);
                    bus.in_valid = 1'b1;
                    tries = 0;
                    do begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk);
                        #1;
                        tries++;
                    end while (!acc && tries < 50);
                end
                bus.in_valid = 1'b0;
            end
            begin : rdy
                int c;
                logic [3:0] pat;
                pat = 4'b1001;
                c = 0;
                while (!bp_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = pat[3 - (c % 4)];
                    c++;
                end
                bus.out_ready = 1'b1;
            end
            begin : mon
                int   idx, cyc;
                logic held;
                logic [19:0] h_re;
                logic [3:0]  h_tag;
                idx = 0;
                cyc = 0;
                held = 1'b0;
                h_re = '0;
                h_tag = '0;
                while (idx < 8 && cyc < 300) begin
                    @(negedge clk);
                    cyc++;
                    if (held) begin
                        chk("bp_hold_re",  $unsigned(bus.out_re), h_re);
                        chk("bp_hold_tag", bus.out_tag, h_tag);
                    end
                    held = 1'b0;
                    if (bus.out_valid && !bus.out_ready) begin
                        chk("bp_in_ready_stall", bus.in_ready, 1'b0);
                        held  = 1'b1;
                        h_re  = $unsigned(bus.out_re);
                        h_tag = bus.out_tag;
                    end
                    if (bus.out_valid && bus.out_ready) begin
                        chk("bp_tag", bus.out_tag, 4'(idx));
                        chk("bp_re",  $unsigned(bus.out_re), 20'(idx << 12));
                        chk("bp_im",  $unsigned(bus.out_im), 20'h0);
                        idx++;
                    end
                end
                chk("bp_count", idx, 8);
                bp_done = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", bus.busy, 1'b0);

        // Reset with three beats in flight
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_x_re  = 18'h10000;
            bus.in_y_re  = 18'h10000;
            bus.in_tag   = 4'(9 + k);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("mid_busy_before", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", bus.out_valid, 1'b0);
        chk("mid_busy",      bus.busy, 1'b0);
        chk("mid_out_tag",   bus.out_tag, 4'h0);
        chk("mid_in_ready",  bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (6) begin
                @(negedge clk);
                seen = seen | bus.out_valid | bus.busy;
            end
            chk("mid_no_stale", seen, 1'b0);
        end

        run_beat("post_rst", 18'h10000, 18'h08000, 18'h08000, 18'h10000, 1'b0, 4'hC,
                 20'h00000, 20'h14000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
